// File: rtl/mcpu_acc_param.sv
// mcpu_acc_param -- parametrised four-instruction accumulator micro-CPU.
//
// Instruction word is {opcode[1:0], addr[AW-1:0]}; DW must equal AW+2.
//   00 NOR : acc <= ~(acc | M[a])
//   01 ADD : {carry, acc} <= acc + M[a]
//   10 STA : M[a] <= acc
//   11 JCC : carry==0 -> pc <= a ; carry==1 -> carry <= 0, fall through
// A taken JCC whose target is its own fetch address parks the CPU in HALT
// until the next reset.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous reset, active low
//   mem_addr   access address (pc during fetch, operand during execute)
//   mem_rd     read request
//   mem_wr     write request
//   mem_wdata  write data, always the accumulator
//   mem_rdata  read data, sampled when mem_rdy=1
//   mem_rdy    access completes at an edge where it is 1 and a request is up
//   acc_out    accumulator
//   carry_out  carry flag
//   halted     CPU is stopped in its halt loop
//   retire     one-cycle pulse after each instruction completes

module mcpu_acc_param #(
  parameter int DW = 8,
  parameter int AW = DW - 2
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rdy,
  output logic [DW-1:0] acc_out,
  output logic          carry_out,
  output logic          halted,
  output logic          retire
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXEC_RD = 2'd1,
    EXEC_WR = 2'd2,
    HALT    = 2'd3
  } state_t;

  localparam logic [1:0] OP_NOR = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_STA = 2'b10;
  localparam logic [1:0] OP_JCC = 2'b11;

  state_t        state, next_state;
  logic [AW-1:0] pc;
  logic [AW-1:0] operand;
  logic [1:0]    opcode;
  logic [DW-1:0] acc;
  logic          carry;

  logic [1:0]    fetch_op;
  logic [AW-1:0] fetch_target;
  logic          halt_hit;
  logic [DW:0]   sum;

  assign fetch_op     = mem_rdata[DW-1:DW-2];
  assign fetch_target = mem_rdata[AW-1:0];
  assign sum          = {1'b0, acc} + {1'b0, mem_rdata};

  // A jump-to-self that would actually be taken is the halt idiom.
  assign halt_hit = (fetch_op == OP_JCC) && !carry && (fetch_target == pc);

  assign mem_wdata = acc;
  assign acc_out   = acc;
  assign carry_out = carry;

  always_ff @(posedge clk) begin
    if (!rst) state <= FETCH;
    else      state <= next_state;
  end

  // Requests are decoded from state only; mem_rdy only steers the next state,
  // so the bus stays stable across wait cycles. Reset gates the requests off
  // immediately so an in-flight access is abandoned.
  always_comb begin
    next_state = state;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = operand;
    case (state)
      FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = pc;
        if (mem_rdy) begin
          case (fetch_op)
            OP_NOR, OP_ADD: next_state = EXEC_RD;
            OP_STA:         next_state = EXEC_WR;
            default:        next_state = halt_hit ? HALT : FETCH;
          endcase
        end
      end
      EXEC_RD: begin
        mem_rd = 1'b1;
        if (mem_rdy) next_state = FETCH;
      end
      EXEC_WR: begin
        mem_wr = 1'b1;
        if (mem_rdy) next_state = FETCH;
      end
      default: next_state = HALT;
    endcase
    if (!rst) begin
      mem_rd = 1'b0;
      mem_wr = 1'b0;
    end
  end

  // Architectural registers. Nothing moves while mem_rdy is low, and HALT
  // touches nothing, so the machine is frozen there until reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc      <= '0;
      operand <= '0;
      opcode  <= OP_NOR;
      acc     <= '0;
      carry   <= 1'b0;
      halted  <= 1'b0;
      retire  <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        FETCH: begin
          if (mem_rdy) begin
            pc      <= pc + AW'(1);
            operand <= fetch_target;
            opcode  <= fetch_op;
            // JCC has no execute phase: resolve and retire on the fetch edge.
            if (fetch_op == OP_JCC) begin
              retire <= 1'b1;
              if (!carry) begin
                pc <= fetch_target;
                if (halt_hit) halted <= 1'b1;
              end else begin
                carry <= 1'b0;
              end
            end
          end
        end
        EXEC_RD: begin
          if (mem_rdy) begin
            retire <= 1'b1;
            if (opcode == OP_ADD) {carry, acc} <= sum;
            else                  acc <= ~(acc | mem_rdata);
          end
        end
        EXEC_WR: begin
          if (mem_rdy) retire <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu_acc_param.sv
// Testbench for mcpu_acc_param (DW=8, AW=6): directed scenarios for reset,
// ALU ops, stores, both JCC paths, wait states, halt and pc wrap, followed by
// randomised programs with random wait states checked against an
// instruction-level reference model.

module tb_mcpu_acc_param;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int MEMSZ = 1 << AW;

  logic          clk;
  logic          rst;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_rdy;
  logic [DW-1:0] acc_out;
  logic          carry_out;
  logic          halted;
  logic          retire;

  logic [DW-1:0] mem [MEMSZ];
  logic [DW-1:0] ref_mem [MEMSZ];
  int            ref_pc;
  int            ref_acc;
  int            ref_carry;
  int            ref_halted;

  int check_count;
  int error_count;
  int retire_count;

  mcpu_acc_param #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_rdy   (mem_rdy),
    .acc_out   (acc_out),
    .carry_out (carry_out),
    .halted    (halted),
    .retire    (retire)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait combinational read port of the memory model.
  assign mem_rdata = mem[mem_addr];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: commit a completing write at the edge, then return just
  // after the falling edge where outputs are sampled and inputs are driven.
  task automatic tick();
    logic          do_wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    do_wr = rst && mem_wr && mem_rdy;
    wa    = mem_addr;
    wd    = mem_wdata;
    @(posedge clk);
    if (do_wr) mem[wa] = wd;
    @(negedge clk);
    #1;
    if (retire) retire_count++;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < MEMSZ; i++) mem[i] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  // Executes one whole instruction of the ISA on the reference state.
  task automatic model_step();
    int instr, op, a, operand_val;
    instr = ref_mem[ref_pc];
    op    = instr / 64;
    a     = instr % 64;
    operand_val = ref_mem[a];
    case (op)
      0: begin
        ref_acc = 255 - (ref_acc | operand_val);
        ref_pc  = (ref_pc + 1) % MEMSZ;
      end
      1: begin
        ref_carry = (ref_acc + operand_val > 255) ? 1 : 0;
        ref_acc   = (ref_acc + operand_val) % 256;
        ref_pc    = (ref_pc + 1) % MEMSZ;
      end
      2: begin
        ref_mem[a] = DW'(ref_acc);
        ref_pc     = (ref_pc + 1) % MEMSZ;
      end
      default: begin
        if (ref_carry == 0) begin
          if (a == ref_pc) ref_halted = 1;
          ref_pc = a;
        end else begin
          ref_carry = 0;
          ref_pc    = (ref_pc + 1) % MEMSZ;
        end
      end
    endcase
  endtask

  // One randomised program run with random wait states, compared instruction
  // by instruction against the reference model, then memory contents compared.
  task automatic applyStimulus(input int round);
    int bad;
    for (int i = 0; i < MEMSZ; i++) begin
      mem[i]     = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    mem_rdy = 1'b1;
    do_reset();
    ref_pc = 0; ref_acc = 0; ref_carry = 0; ref_halted = 0;
    checkOutput($sformatf("r%0d_first_fetch", round), {mem_rd, mem_addr}, {1'b1, 6'd0});
    for (int c = 0; c < 400; c++) begin
      mem_rdy = ($urandom_range(0, 3) != 0);
      tick();
      if (retire) begin
        model_step();
        checkOutput($sformatf("r%0d_acc", round), acc_out, ref_acc);
        checkOutput($sformatf("r%0d_carry", round), carry_out, ref_carry);
        checkOutput($sformatf("r%0d_halted", round), halted, ref_halted);
        if (ref_halted == 0)
          checkOutput($sformatf("r%0d_next_fetch", round), {mem_rd, mem_addr},
                      {1'b1, 6'(ref_pc)});
        else
          checkOutput($sformatf("r%0d_halt_bus", round), {mem_rd, mem_wr}, 2'b00);
      end
      if (ref_halted != 0) break;
    end
    bad = 0;
    for (int i = 0; i < MEMSZ; i++) if (mem[i] !== ref_mem[i]) bad++;
    checkOutput($sformatf("r%0d_mem_image", round), bad, 0);
  endtask

  // Directed scenarios followed by the randomised rounds.
  initial begin
    int busy;
    check_count  = 0;
    error_count  = 0;
    retire_count = 0;
    rst     = 1'b0;
    mem_rdy = 1'b1;
    clear_mem();
    mem[0]    = 8'h3E;  // NOR 0x3E
    mem[8'h3E]= 8'hDF;
    mem[1]    = 8'h50;  // ADD 0x10
    mem[8'h10]= 8'hF0;
    mem[2]    = 8'h10;  // NOR 0x10
    mem[3]    = 8'h30;  // NOR 0x30
    mem[8'h30]= 8'h30;
    mem[4]    = 8'hA1;  // STA 0x21
    mem[5]    = 8'hC7;  // JCC 0x07 (carry=1: not taken)
    mem[6]    = 8'hC8;  // JCC 0x08 (carry=0: taken)
    mem[8]    = 8'h51;  // ADD 0x11
    mem[8'h11]= 8'h01;
    mem[9]    = 8'hC9;  // JCC to self: halt

    tick();
    tick();
    checkOutput("reset_no_req", {mem_rd, mem_wr}, 2'b00);
    rst = 1'b1;
    #1;
    checkOutput("first_fetch", {mem_rd, mem_addr}, {1'b1, 6'd0});
    checkOutput("reset_acc", acc_out, 8'h00);
    checkOutput("reset_flags", {carry_out, halted, retire}, 3'b000);

    tick();
    tick();
    checkOutput("nor_preset", acc_out, 8'h20);
    retire_count = 0;
    tick();
    tick();
    checkOutput("add_acc", acc_out, 8'h10);
    checkOutput("add_carry", carry_out, 1'b1);
    checkOutput("add_retires", retire_count, 1);

    tick();
    tick();
    checkOutput("nor_0f", acc_out, 8'h0F);
    tick();
    tick();
    checkOutput("nor_c0", acc_out, 8'hC0);
    checkOutput("nor_carry_kept", carry_out, 1'b1);
    tick();
    checkOutput("sta_bus", {mem_wr, mem_rd, mem_addr, mem_wdata}, {2'b10, 6'h21, 8'hC0});
    tick();
    checkOutput("sta_one_cycle", mem_wr, 1'b0);
    checkOutput("sta_mem", mem[8'h21], 8'hC0);
    checkOutput("fetch_after_sta", {mem_rd, mem_addr}, {1'b1, 6'd5});

    tick();
    checkOutput("jcc_nt_fetch", mem_addr, 6'd6);
    checkOutput("jcc_nt_carry", carry_out, 1'b0);
    tick();
    checkOutput("jcc_t_fetch", mem_addr, 6'd8);

    // ADD with three fetch wait cycles and two execute wait cycles.
    retire_count = 0;
    busy = 0;
    mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (!(mem_rd && !mem_wr && mem_addr == 6'd8)) busy++;
    end
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (!(mem_rd && !mem_wr && mem_addr == 6'h11)) busy++;
    end
    checkOutput("wait_bus_stable", busy, 0);
    checkOutput("wait_no_early_retire", retire_count, 0);
    mem_rdy = 1'b1;
    tick();
    checkOutput("wait_add_acc", {carry_out, acc_out}, {1'b0, 8'hC1});
    checkOutput("wait_retires", retire_count, 1);

    tick();
    checkOutput("halt_flag", {halted, retire}, 2'b11);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_rd || mem_wr) busy++;
    end
    checkOutput("halt_quiet", busy, 0);
    checkOutput("halt_acc_frozen", acc_out, 8'hC1);
    do_reset();
    checkOutput("halt_cleared", {halted, acc_out}, {1'b0, 8'h00});

    // Reset while an EXEC_RD read is in flight.
    tick();
    checkOutput("exec_rd_addr", {mem_rd, mem_addr}, {1'b1, 6'h3E});
    rst = 1'b0;
    #1;
    checkOutput("abort_rd_drop", mem_rd, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("abort_no_effect", {retire, acc_out, mem_addr}, {1'b0, 8'h00, 6'd0});

    // pc wrap from 0x3F, then a jump-to-self halt at 0x3F.
    clear_mem();
    mem[0]     = 8'hFF;  // JCC 0x3F
    mem[8'h3F] = 8'h7E;  // ADD 0x3E (M=0)
    do_reset();
    tick();
    checkOutput("jump_3f", mem_addr, 6'h3F);
    tick();
    tick();
    checkOutput("wrap_fetch", {mem_rd, mem_addr}, {1'b1, 6'd0});
    mem[8'h3F] = 8'hFF;
    tick();
    tick();
    checkOutput("halt_3f", halted, 1'b1);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_rd || mem_wr) busy++;
    end
    checkOutput("halt_3f_quiet", busy, 0);
    do_reset();
    checkOutput("halt_3f_cleared", halted, 1'b0);

    for (int r = 0; r < 12; r++) applyStimulus(r);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
